page_qspi_arbiter: RTL and testbench

- Sits directly upstream of the array of cached memory pages; owns the single QSPI device port and decides which page may use it.
- Each page raises a load request (qspi_requestData) or a flush request (qspi_storeData); the arbiter grants exactly one page at a time by driving that page's pageLoading or pageFlushing.
- Also decodes the bus address into the one-hot pageSelected vector.

---
 rtl/page_qspi_arbiter_pkg.sv | 26 ++
 rtl/page_qspi_arbiter_if.sv | 41 ++++
 rtl/page_qspi_arbiter_rr_priority_select.sv | 27 ++
 rtl/page_qspi_arbiter.sv | 114 +++++++++++
 tb/tb_page_qspi_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/page_qspi_arbiter_pkg.sv
// Shared constants, types and FSM encoding for the page/QSPI arbiter.
package page_qspi_arbiter_pkg;

  localparam int PAGE_INDEX_ADDRESS_SIZE = 4;
  localparam int PAGE_COUNT              = 2 ** PAGE_INDEX_ADDRESS_SIZE;
  localparam int PAGE_DATA_ADDRESS_SIZE  = 5;
  localparam int BUS_ADDR_W              = 24;
  localparam int WORD_COUNT_W            = 16;

  // Index field position inside the bus address
  localparam int PAGE_IDX_LSB = PAGE_DATA_ADDRESS_SIZE + 2;
  localparam int PAGE_IDX_MSB = PAGE_INDEX_ADDRESS_SIZE + PAGE_DATA_ADDRESS_SIZE + 1;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT   = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  typedef logic [PAGE_COUNT-1:0]              page_vec_t;
  typedef logic [PAGE_INDEX_ADDRESS_SIZE-1:0] page_idx_t;

  function automatic page_vec_t onehot(input page_idx_t idx);
    return page_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/page_qspi_arbiter_if.sv
// Bundle between the page array / QSPI device side and the arbiter.
//
// Handshake: a page holds page_requestData or page_storeData high for as long
// as it wants the QSPI port. The arbiter answers with a one-hot
// pageLoading/pageFlushing that mirrors the owner's live request; the page
// drops its request to hand the port back, and must not assume a grant in
// the cycle its request first rises.
interface page_qspi_arbiter_if;
  import page_qspi_arbiter_pkg::*;

  logic                    automaticPaging;
  logic                    automaticPagingChanged;
  logic [BUS_ADDR_W-1:0]   busVirtualAddress;
  page_vec_t               page_requestData;
  page_vec_t               page_storeData;
  logic                    qspi_busy;
  logic                    qspi_wordComplete;
  page_vec_t               pageSelected;
  page_vec_t               pageLoading;
  page_vec_t               pageFlushing;
  logic                    owner_valid;
  page_idx_t               owner_index;
  logic [WORD_COUNT_W-1:0] word_count;
  logic [1:0]              dbg_state;
  page_idx_t               dbg_pointer;

  modport master (
    output automaticPaging, automaticPagingChanged, busVirtualAddress,
           page_requestData, page_storeData, qspi_busy, qspi_wordComplete,
    input  pageSelected, pageLoading, pageFlushing, owner_valid, owner_index,
           word_count, dbg_state, dbg_pointer
  );

  modport slave (
    input  automaticPaging, automaticPagingChanged, busVirtualAddress,
           page_requestData, page_storeData, qspi_busy, qspi_wordComplete,
    output pageSelected, pageLoading, pageFlushing, owner_valid, owner_index,
           word_count, dbg_state, dbg_pointer
  );

endinterface

// File: rtl/page_qspi_arbiter_rr_priority_select.sv
// Round-robin picker: first set bit of i_req at or after i_ptr, wrapping.
module page_qspi_arbiter_rr_priority_select
  import page_qspi_arbiter_pkg::*;
(
  input  page_vec_t i_req,
  input  page_idx_t i_ptr,
  output logic      o_found,
  output page_idx_t o_index
);

  page_idx_t w_idx;

  // Walk outward from the pointer; the index width makes the wrap free
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int k = 0; k < PAGE_COUNT; k++) begin
      w_idx = i_ptr + page_idx_t'(k);
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/page_qspi_arbiter.sv
// Page/QSPI arbiter: grants the single QSPI port to one page at a time and
// decodes the bus address into a one-hot page select.
// Optional macro PAGE_ARBITER_FLUSH_PRIORITY_EN: pending flushes win over
// loads in IDLE (still round-robin among flushers).
module page_qspi_arbiter
  import page_qspi_arbiter_pkg::*;
(
  input logic                clk,
  input logic                rst,
  page_qspi_arbiter_if.slave bus
);

  logic [1:0]              r_state;
  page_idx_t               r_ptr;
  page_idx_t               r_owner;
  logic                    r_valid;
  logic [WORD_COUNT_W-1:0] r_count;

  page_vec_t w_req;
  logic      w_found;
  page_idx_t w_index;
  logic      w_in_grant;
  logic      w_unused;

  assign w_req      = bus.page_requestData | bus.page_storeData;
  assign w_in_grant = (r_state == ST_GRANT);

  // Mode select does not alter decode; address bits outside the index field are ignored
  assign w_unused = ^{bus.automaticPaging,
                      bus.busVirtualAddress[BUS_ADDR_W-1:PAGE_IDX_MSB+1],
                      bus.busVirtualAddress[PAGE_IDX_LSB-1:0]};

`ifdef PAGE_ARBITER_FLUSH_PRIORITY_EN
  logic      w_flush_found;
  page_idx_t w_flush_index;
  logic      w_all_found;
  page_idx_t w_all_index;

  page_qspi_arbiter_rr_priority_select u_sel_flush (
    .i_req   (bus.page_storeData),
    .i_ptr   (r_ptr),
    .o_found (w_flush_found),
    .o_index (w_flush_index)
  );

  page_qspi_arbiter_rr_priority_select u_sel_all (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_found (w_all_found),
    .o_index (w_all_index)
  );

  assign w_found = w_flush_found | w_all_found;
  assign w_index = w_flush_found ? w_flush_index : w_all_index;
`else
  page_qspi_arbiter_rr_priority_select u_sel_all (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_index (w_index)
  );
`endif

  assign bus.pageSelected = onehot(bus.busVirtualAddress[PAGE_IDX_MSB:PAGE_IDX_LSB]);

  // Grant type tracks the owner's live request so load<->flush switches keep the port
  assign bus.pageLoading  = (w_in_grant && bus.page_requestData[r_owner]) ? onehot(r_owner) : '0;
  assign bus.pageFlushing = (w_in_grant && bus.page_storeData[r_owner])   ? onehot(r_owner) : '0;

  assign bus.owner_valid = r_valid;
  assign bus.owner_index = r_owner;
  assign bus.word_count  = r_count;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_pointer = r_ptr;

  // Arbitration FSM: IDLE picks, GRANT counts words, RELEASE advances the pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found && !bus.qspi_busy) begin
            r_owner <= w_index;
            r_valid <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (bus.qspi_wordComplete && (r_count != '1))
            r_count <= r_count + 1'b1;
          if (!w_req[r_owner] || bus.automaticPagingChanged) begin
            r_valid <= 1'b0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_ptr   <= r_owner + 1'b1;
          r_count <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_page_qspi_arbiter.sv
// Bench for page_qspi_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration rules.
module tb_page_qspi_arbiter;
  import page_qspi_arbiter_pkg::*;

  localparam int M_IDLE    = 0;
  localparam int M_GRANT   = 1;
  localparam int M_RELEASE = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // Behavioural model state
  int   m_mode;
  int   m_owner;
  int   m_ptr;
  int   m_count;
  logic [3:0] exp_q[$];

  page_qspi_arbiter_if bus_if();

  page_qspi_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model ----------------
  function automatic int first_from(input logic [15:0] v, input int p);
    for (int k = 0; k < PAGE_COUNT; k++)
      if (v[(p + k) % PAGE_COUNT]) return (p + k) % PAGE_COUNT;
    return 0;
  endfunction

  function automatic logic [15:0] exp_sel();
    logic [23:0] a;
    a = bus_if.busVirtualAddress;
    return 16'h1 << ((int'(a) / 128) % 16);
  endfunction

  function automatic logic [15:0] exp_load();
    if (m_mode == M_GRANT && bus_if.page_requestData[m_owner]) return 16'h1 << m_owner;
    return 16'h0;
  endfunction

  function automatic logic [15:0] exp_flush();
    if (m_mode == M_GRANT && bus_if.page_storeData[m_owner]) return 16'h1 << m_owner;
    return 16'h0;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_idle_inputs();
    bus_if.automaticPaging        = 1'b0;
    bus_if.automaticPagingChanged = 1'b0;
    bus_if.busVirtualAddress      = 24'h0;
    bus_if.page_requestData       = 16'h0;
    bus_if.page_storeData         = 16'h0;
    bus_if.qspi_busy              = 1'b0;
    bus_if.qspi_wordComplete      = 1'b0;
  endtask

  // Advance the model from the inputs seen at this edge, then clock the DUT
  task automatic cycle();
    logic [15:0] rq;
    rq = bus_if.page_requestData | bus_if.page_storeData;
    case (m_mode)
      M_IDLE: begin
        if (rq != 16'h0 && !bus_if.qspi_busy) begin
`ifdef PAGE_ARBITER_FLUSH_PRIORITY_EN
          if (bus_if.page_storeData != 16'h0) m_owner = first_from(bus_if.page_storeData, m_ptr);
          else m_owner = first_from(rq, m_ptr);
`else
          m_owner = first_from(rq, m_ptr);
`endif
          m_mode = M_GRANT;
          exp_q.push_back(4'(m_owner));
        end
      end
      M_GRANT: begin
        if (bus_if.qspi_wordComplete && m_count < 65535) m_count = m_count + 1;
        if (!rq[m_owner] || bus_if.automaticPagingChanged) m_mode = M_RELEASE;
      end
      default: begin
        m_ptr   = (m_owner + 1) % PAGE_COUNT;
        m_count = 0;
        m_mode  = M_IDLE;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle_inputs();
    rst     = 1'b1;
    m_mode  = M_IDLE;
    m_owner = 0;
    m_ptr   = 0;
    m_count = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (bus_if.pageLoading !== 16'h0) begin n_errors++; $display("FAIL reset_loading: got %h want 0000", bus_if.pageLoading); end
    n_checks++; if (bus_if.pageFlushing !== 16'h0) begin n_errors++; $display("FAIL reset_flushing: got %h want 0000", bus_if.pageFlushing); end
    n_checks++; if (bus_if.owner_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus_if.owner_valid); end
    n_checks++; if (bus_if.owner_index !== 4'd0) begin n_errors++; $display("FAIL reset_index: got %0d want 0", bus_if.owner_index); end
    n_checks++; if (bus_if.word_count !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", bus_if.word_count); end
    n_checks++; if (bus_if.dbg_pointer !== 4'd0) begin n_errors++; $display("FAIL reset_pointer: got %0d want 0", bus_if.dbg_pointer); end
    bus_if.busVirtualAddress = 24'h000380;
    #1;
    n_checks++; if (bus_if.pageSelected !== 16'h0080) begin n_errors++; $display("FAIL sel_page7: got %h want 0080", bus_if.pageSelected); end
    bus_if.busVirtualAddress = 24'hFFFC7F;
    bus_if.automaticPaging   = 1'b1;
    #1;
    n_checks++; if (bus_if.pageSelected !== 16'h0100) begin n_errors++; $display("FAIL sel_page8_auto: got %h want 0100", bus_if.pageSelected); end
    bus_if.automaticPaging = 1'b0;
    #1;
    n_checks++; if (bus_if.pageSelected !== 16'h0100) begin n_errors++; $display("FAIL sel_page8_manual: got %h want 0100", bus_if.pageSelected); end
  endtask

  task automatic test_single_request();
    do_reset();
    bus_if.page_requestData = 16'h0008;
    #1;
    n_checks++; if (bus_if.pageLoading !== 16'h0) begin n_errors++; $display("FAIL single_same_cycle: got %h want 0000", bus_if.pageLoading); end
    cycle();
    n_checks++; if (bus_if.pageLoading !== 16'h0008) begin n_errors++; $display("FAIL single_loading: got %h want 0008", bus_if.pageLoading); end
    n_checks++; if (bus_if.owner_index !== 4'd3) begin n_errors++; $display("FAIL single_index: got %0d want 3", bus_if.owner_index); end
    n_checks++; if (bus_if.owner_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b want 1", bus_if.owner_valid); end
    repeat (3) begin
      bus_if.qspi_wordComplete = 1'b1;
      cycle();
    end
    bus_if.qspi_wordComplete = 1'b0;
    n_checks++; if (bus_if.word_count !== 16'd3) begin n_errors++; $display("FAIL single_count: got %0d want 3", bus_if.word_count); end
    // load -> flush on the same page keeps the grant
    bus_if.page_requestData = 16'h0;
    bus_if.page_storeData   = 16'h0008;
    #1;
    n_checks++; if (bus_if.pageFlushing !== 16'h0008 || bus_if.pageLoading !== 16'h0) begin n_errors++; $display("FAIL single_switch: got L=%h F=%h want L=0000 F=0008", bus_if.pageLoading, bus_if.pageFlushing); end
    cycle();
    n_checks++; if (bus_if.owner_valid !== 1'b1) begin n_errors++; $display("FAIL single_switch_valid: got %b want 1", bus_if.owner_valid); end
    // drop together with a word pulse: count still increments
    bus_if.page_storeData    = 16'h0;
    bus_if.qspi_wordComplete = 1'b1;
    cycle();
    bus_if.qspi_wordComplete = 1'b0;
    n_checks++; if (bus_if.word_count !== 16'd4) begin n_errors++; $display("FAIL single_last_word: got %0d want 4", bus_if.word_count); end
    n_checks++; if (bus_if.owner_valid !== 1'b0 || bus_if.pageFlushing !== 16'h0) begin n_errors++; $display("FAIL single_release: got V=%b F=%h want V=0 F=0000", bus_if.owner_valid, bus_if.pageFlushing); end
    cycle();
    n_checks++; if (bus_if.word_count !== 16'd0) begin n_errors++; $display("FAIL single_count_clear: got %0d want 0", bus_if.word_count); end
    n_checks++; if (bus_if.dbg_pointer !== 4'd4) begin n_errors++; $display("FAIL single_pointer: got %0d want 4", bus_if.dbg_pointer); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus_if.page_requestData = 16'h0009;
    cycle();
    n_checks++; if (bus_if.pageLoading !== 16'h0001) begin n_errors++; $display("FAIL rr_first: got %h want 0001", bus_if.pageLoading); end
    bus_if.page_requestData = 16'h0008;
    cycle();
    n_checks++; if (bus_if.pageLoading !== 16'h0 || bus_if.pageFlushing !== 16'h0 || bus_if.owner_valid !== 1'b0) begin n_errors++; $display("FAIL rr_release: got L=%h F=%h V=%b want all 0", bus_if.pageLoading, bus_if.pageFlushing, bus_if.owner_valid); end
    n_checks++; if (bus_if.dbg_state !== ST_RELEASE) begin n_errors++; $display("FAIL rr_release_state: got %b want 10", bus_if.dbg_state); end
    cycle();
    n_checks++; if (bus_if.owner_valid !== 1'b0 || bus_if.dbg_pointer !== 4'd1) begin n_errors++; $display("FAIL rr_idle: got V=%b P=%0d want V=0 P=1", bus_if.owner_valid, bus_if.dbg_pointer); end
    cycle();
    n_checks++; if (bus_if.pageLoading !== 16'h0008 || bus_if.owner_index !== 4'd3) begin n_errors++; $display("FAIL rr_second: got L=%h I=%0d want L=0008 I=3", bus_if.pageLoading, bus_if.owner_index); end
    bus_if.page_requestData = 16'h0;
    cycle();
    cycle();
    n_checks++; if (bus_if.dbg_pointer !== 4'd4) begin n_errors++; $display("FAIL rr_pointer: got %0d want 4", bus_if.dbg_pointer); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus_if.page_requestData = 16'h4000;
    cycle();
    bus_if.page_requestData = 16'h0;
    cycle();
    cycle();
    n_checks++; if (bus_if.dbg_pointer !== 4'd15) begin n_errors++; $display("FAIL wrap_ptr15: got %0d want 15", bus_if.dbg_pointer); end
    bus_if.page_requestData = 16'h8001;
    cycle();
    n_checks++; if (bus_if.pageLoading !== 16'h8000 || bus_if.owner_index !== 4'd15) begin n_errors++; $display("FAIL wrap_first: got L=%h I=%0d want L=8000 I=15", bus_if.pageLoading, bus_if.owner_index); end
    bus_if.page_requestData = 16'h0001;
    cycle();
    cycle();
    n_checks++; if (bus_if.dbg_pointer !== 4'd0) begin n_errors++; $display("FAIL wrap_ptr0: got %0d want 0", bus_if.dbg_pointer); end
    cycle();
    n_checks++; if (bus_if.pageLoading !== 16'h0001 || bus_if.owner_index !== 4'd0) begin n_errors++; $display("FAIL wrap_second: got L=%h I=%0d want L=0001 I=0", bus_if.pageLoading, bus_if.owner_index); end
    bus_if.page_requestData = 16'h0;
    cycle();
    cycle();
  endtask

  task automatic test_busy();
    do_reset();
    bus_if.qspi_busy        = 1'b1;
    bus_if.page_requestData = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++; if (bus_if.owner_valid !== 1'b0) begin n_errors++; $display("FAIL busy_hold_%0d: got %b want 0", i, bus_if.owner_valid); end
    end
    bus_if.qspi_busy = 1'b0;
    #1;
    n_checks++; if (bus_if.owner_valid !== 1'b0) begin n_errors++; $display("FAIL busy_fall_cycle: got %b want 0", bus_if.owner_valid); end
    cycle();
    n_checks++; if (bus_if.pageLoading !== 16'h0002 || bus_if.owner_index !== 4'd1) begin n_errors++; $display("FAIL busy_grant: got L=%h I=%0d want L=0002 I=1", bus_if.pageLoading, bus_if.owner_index); end
    // release is not held off by busy
    bus_if.qspi_busy        = 1'b1;
    bus_if.page_requestData = 16'h0;
    cycle();
    n_checks++; if (bus_if.dbg_state !== ST_RELEASE) begin n_errors++; $display("FAIL busy_release: got %b want 10", bus_if.dbg_state); end
    bus_if.qspi_busy = 1'b0;
    cycle();
  endtask

  task automatic test_forced_release();
    do_reset();
    bus_if.automaticPagingChanged = 1'b1;   // pulse in IDLE is ignored
    bus_if.page_requestData       = 16'h0020;
    cycle();
    n_checks++; if (bus_if.owner_valid !== 1'b1 || bus_if.owner_index !== 4'd5) begin n_errors++; $display("FAIL force_grant: got V=%b I=%0d want V=1 I=5", bus_if.owner_valid, bus_if.owner_index); end
    bus_if.automaticPagingChanged = 1'b0;
    cycle();
    bus_if.automaticPagingChanged = 1'b1;
    cycle();
    bus_if.automaticPagingChanged = 1'b0;
    n_checks++; if (bus_if.pageLoading !== 16'h0 || bus_if.owner_valid !== 1'b0) begin n_errors++; $display("FAIL force_release: got L=%h V=%b want L=0000 V=0", bus_if.pageLoading, bus_if.owner_valid); end
    cycle();
    n_checks++; if (bus_if.dbg_pointer !== 4'd6) begin n_errors++; $display("FAIL force_pointer: got %0d want 6", bus_if.dbg_pointer); end
    cycle();
    n_checks++; if (bus_if.pageLoading !== 16'h0020) begin n_errors++; $display("FAIL force_regrant: got %h want 0020", bus_if.pageLoading); end
    bus_if.qspi_wordComplete = 1'b1;
    cycle();
    bus_if.qspi_wordComplete = 1'b0;
    n_checks++; if (bus_if.word_count !== 16'd1) begin n_errors++; $display("FAIL force_count: got %0d want 1", bus_if.word_count); end
    // asynchronous reset mid-grant, checked well before the next edge
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus_if.pageLoading !== 16'h0 || bus_if.owner_valid !== 1'b0) begin n_errors++; $display("FAIL async_grant: got L=%h V=%b want L=0000 V=0", bus_if.pageLoading, bus_if.owner_valid); end
    n_checks++; if (bus_if.owner_index !== 4'd0 || bus_if.word_count !== 16'd0) begin n_errors++; $display("FAIL async_regs: got I=%0d C=%0d want 0 0", bus_if.owner_index, bus_if.word_count); end
    do_reset();
  endtask

  task automatic test_flush_priority();
    do_reset();
    bus_if.page_requestData = 16'h0002;
    bus_if.page_storeData   = 16'h0010;
    cycle();
`ifdef PAGE_ARBITER_FLUSH_PRIORITY_EN
    n_checks++; if (bus_if.pageFlushing !== 16'h0010 || bus_if.owner_index !== 4'd4) begin n_errors++; $display("FAIL prio_flush_first: got F=%h I=%0d want F=0010 I=4", bus_if.pageFlushing, bus_if.owner_index); end
`else
    n_checks++; if (bus_if.pageLoading !== 16'h0002 || bus_if.owner_index !== 4'd1) begin n_errors++; $display("FAIL prio_load_first: got L=%h I=%0d want L=0002 I=1", bus_if.pageLoading, bus_if.owner_index); end
`endif
    bus_if.page_requestData = 16'h0;
    bus_if.page_storeData   = 16'h0;
    cycle();
    cycle();
  endtask

  task automatic test_random();
    logic prev_valid;
    logic [3:0] exp_owner;
    do_reset();
    prev_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus_if.page_requestData = bus_if.page_requestData ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) bus_if.page_storeData   = bus_if.page_storeData ^ (16'h1 << $urandom_range(0, 15));
      bus_if.qspi_busy              = ($urandom_range(0, 4) == 0);
      bus_if.qspi_wordComplete      = 1'($urandom_range(0, 1));
      bus_if.automaticPagingChanged = ($urandom_range(0, 19) == 0);
      bus_if.automaticPaging        = 1'($urandom_range(0, 1));
      bus_if.busVirtualAddress      = 24'($urandom);
      #1;
      n_checks++; if (bus_if.pageSelected !== exp_sel()) begin n_errors++; $display("FAIL rand_sel c%0d: got %h want %h", c, bus_if.pageSelected, exp_sel()); end
      n_checks++; if (bus_if.pageLoading !== exp_load()) begin n_errors++; $display("FAIL rand_load c%0d: got %h want %h", c, bus_if.pageLoading, exp_load()); end
      n_checks++; if (bus_if.pageFlushing !== exp_flush()) begin n_errors++; $display("FAIL rand_flush c%0d: got %h want %h", c, bus_if.pageFlushing, exp_flush()); end
      n_checks++; if (bus_if.owner_valid !== (m_mode == M_GRANT)) begin n_errors++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus_if.owner_valid, (m_mode == M_GRANT)); end
      n_checks++; if (bus_if.owner_index !== 4'(m_owner)) begin n_errors++; $display("FAIL rand_index c%0d: got %0d want %0d", c, bus_if.owner_index, m_owner); end
      n_checks++; if (bus_if.word_count !== 16'(m_count)) begin n_errors++; $display("FAIL rand_count c%0d: got %0d want %0d", c, bus_if.word_count, m_count); end
      n_checks++; if (bus_if.dbg_pointer !== 4'(m_ptr)) begin n_errors++; $display("FAIL rand_pointer c%0d: got %0d want %0d", c, bus_if.dbg_pointer, m_ptr); end
      if (bus_if.owner_valid === 1'b1 && prev_valid === 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL rand_sb_unexpected c%0d: got grant %0d want none", c, bus_if.owner_index);
        end else begin
          exp_owner = exp_q.pop_front();
          if (bus_if.owner_index !== exp_owner) begin n_errors++; $display("FAIL rand_sb_owner c%0d: got %0d want %0d", c, bus_if.owner_index, exp_owner); end
        end
      end
      prev_valid = bus_if.owner_valid;
      cycle();
    end
    n_checks++; if (exp_q.size() > 1) begin n_errors++; $display("FAIL rand_sb_leftover: got %0d want <=1", exp_q.size()); end
    drive_idle_inputs();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    drive_idle_inputs();
    test_reset();
    test_single_request();
    test_round_robin();
    test_wrap();
    test_busy();
    test_forced_release();
    test_flush_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
